diff_tx_serializer: RTL and testbench
=====================================

# diff_tx_serializer

Source-synchronous serializer that drives the forwarded-clock and data lanes of the chip-to-chip differential link. It accepts 16-bit words from on-chip logic over a valid/ready handshake and shifts them out MSB first. It generates a gated forwarded clock whose rising edge lands mid-bit, and inserts an idle gap between words so the far-end receiver can re-frame. Its outputs feed the differential pad drivers.

## Interface
Parameters:
- WIDTH, 16, word length in bits (≥2)
- DIV, 1, forwarded-clock half-period in clk cycles (≥1)
- GAP_BITS, 2, idle bit periods between words (≥0)

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  reset, asynchronous and active-high
- in_data  input  WIDTH  word to transmit, MSB sent first
- in_valid  input  1  in_data holds a word to transmit
- in_ready  output  1  serializer can accept a word
- tx_clk  output  1  forwarded clock to clock-lane driver; low when idle
- tx_data  output  1  serial data to data-lane driver; low when idle
- tx_en  output  1  driver enable, high while a word or gap is in progress
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, SHIFT, GAP.
- Reset (async): state=IDLE, all counters and the shift register 0. Outputs: in_ready=1, tx_clk=0, tx_data=0, tx_en=0, busy=0. If reset asserts mid-word, the word is dropped; there is no partial replay.
- IDLE: in_ready=1. On in_valid&&in_ready, load the shift register with in_data, clear the bit and phase counters, and go to SHIFT. in_data is not sampled after that edge.
- SHIFT: the phase counter counts 0..2*DIV-1.
  - tx_clk is 0 for phase < DIV and 1 for phase ≥ DIV.
  - tx_data = shift register MSB.
  - When the phase wraps (falling edge of tx_clk), shift left by 1, fill with 0, and increment bit_cnt.
  - When bit_cnt reaches WIDTH-1 and the phase wraps, go to GAP if GAP_BITS>0, else go to IDLE.
- GAP: tx_clk=0 and tx_data=0 for GAP_BITS*2*DIV cycles, then go to IDLE.
- tx_en=busy=1 in SHIFT and GAP. in_ready=0 in SHIFT and GAP.
- Data changes only while tx_clk is low. The receiver samples on the tx_clk rising edge and sees exactly WIDTH rising edges per word.
- in_valid asserted while in_ready=0 has no effect. The producer holds in_valid and in_data until the handshake.
- in_valid deasserting in the same cycle as acceptance does not matter; the handshake is evaluated on the edge only.

## Timing
- Acceptance edge = cycle 0. Bit j (j=0 is the MSB) is on tx_data for cycles 1+2jDIV through 2(j+1)DIV. tx_clk rises at cycle 1+2jDIV+DIV.
- The first tx_clk rise comes DIV+1 cycles after acceptance.
- GAP is entered at cycle 1+2*WIDTH*DIV. in_ready returns to 1 at cycle 1+2*DIV*(WIDTH+GAP_BITS).
- Default parameters: SHIFT spans cycles 1–32, GAP spans cycles 33–36, in_ready=1 at cycle 37. Back-to-back word period is 37 cycles.
- GAP_BITS=0: in_ready=1 at cycle 1+2*WIDTH*DIV. tx_clk stays low for at least one cycle between words.
- All outputs are registered, with no combinational path from any input to any output.

## Test plan
- Reset: assert rst asynchronously mid-cycle with no clock. in_ready=1 and tx_clk=tx_data=tx_en=busy=0 immediately. Release rst, then hold in_valid=0 for 10 cycles: outputs stay unchanged.
- Single word, defaults: in_data=16'hA5C3. The bits captured on tx_clk rising edges are 1010010111000011. There are exactly 16 rises, the first at cycle 2. in_ready=1 at cycle 37.
- Back-to-back: hold in_valid=1 with 16'hFFFF, then 16'h0001. Second acceptance at cycle 37. tx_data=0 and tx_clk=0 through cycles 33–36. The second word decodes as 0x0001.
- DIV=3, GAP_BITS=0, WIDTH=8, in_data=8'h81: tx_clk period is 6 cycles. Bit 7 is on cycles 1–6 and the rise is at cycle 4. in_ready=1 at cycle 49.
- Reset mid-word: assert rst at cycle 10 of a word. Outputs return to reset values at once. The next accepted word 16'h1234 transmits cleanly.
- Handshake stall: assert in_valid with 16'h5555 during SHIFT of a prior word. That word is not lost: it is accepted exactly at the cycle in_ready returns high, and no extra word is sent.

Source files
------------

// File: rtl/diff_tx_serializer_if.sv
// Word handshake between on-chip producer logic and the link serializer.
// The producer holds in_data/in_valid until in_ready is seen high on a clock edge.
interface diff_tx_serializer_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    // Producer side: offers words, watches ready.
    modport master (output in_data, output in_valid, input in_ready);
    // Serializer side: consumes words, drives ready.
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/diff_tx_serializer.sv
// Source-synchronous serializer for the chip-to-chip differential link.
// Words are shifted out MSB first with a gated forwarded clock whose rising edge
// sits in the middle of each bit, followed by an idle gap so the receiver can
// re-frame. Every output comes straight from a flop: the next-state logic is
// evaluated once and both the FSM state and the pad-facing outputs are
// registered from it, so outputs reflect the state entered on the same edge.
module diff_tx_serializer #(
    parameter int WIDTH    = 16,
    parameter int DIV      = 1,
    parameter int GAP_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    diff_tx_serializer_if.slave  in_bus,
    output logic                 tx_clk,
    output logic                 tx_data,
    output logic                 tx_en,
    output logic                 busy
);

    localparam int PH_W    = $clog2(2 * DIV);
    localparam int BIT_W   = $clog2(WIDTH);
    localparam int GAP_CYC = GAP_BITS * 2 * DIV;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    // Last phase of a bit period (forwarded-clock falling edge follows it).
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * DIV - 1);
    // First phase in which the forwarded clock is high (mid-bit).
    localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state,   state_n;
    logic [PH_W-1:0]    phase,   phase_n;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic [WIDTH-1:0]   shreg,   shreg_n;

    logic               in_ready_q, in_ready_n;
    logic               tx_clk_q,   tx_clk_n;
    logic               tx_data_q,  tx_data_n;
    logic               tx_en_q,    tx_en_n;
    logic               busy_q,     busy_n;

    assign in_bus.in_ready = in_ready_q;
    assign tx_clk          = tx_clk_q;
    assign tx_data         = tx_data_q;
    assign tx_en           = tx_en_q;
    assign busy            = busy_q;

    // Next-state, counter and output decode; outputs are derived from the
    // state being entered so the registered copies line up with it.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        shreg_n   = shreg;

        case (state)
            IDLE: begin
                if (in_bus.in_valid && in_ready_q) begin
                    shreg_n   = in_bus.in_data;
                    phase_n   = '0;
                    bit_cnt_n = '0;
                    state_n   = SHIFT;
                end
            end

            SHIFT: begin
                if (phase == PH_LAST) begin
                    // Falling edge of the forwarded clock: advance to the next bit.
                    phase_n = '0;
                    shreg_n = {shreg[WIDTH-2:0], 1'b0};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_n = '0;
                        gap_cnt_n = '0;
                        state_n   = (GAP_CYC > 0) ? GAP : IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    phase_n = phase + PH_W'(1);
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_n = '0;
                    state_n   = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        in_ready_n = (state_n == IDLE);
        busy_n     = (state_n != IDLE);
        tx_en_n    = (state_n != IDLE);
        // Clock and data are forced low outside SHIFT so the lanes idle quietly.
        tx_clk_n   = (state_n == SHIFT) && (phase_n >= PH_RISE);
        tx_data_n  = (state_n == SHIFT) && shreg_n[WIDTH-1];
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            in_ready_q <= 1'b1;
            tx_clk_q   <= 1'b0;
            tx_data_q  <= 1'b0;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            shreg      <= shreg_n;
            in_ready_q <= in_ready_n;
            tx_clk_q   <= tx_clk_n;
            tx_data_q  <= tx_data_n;
            tx_en_q    <= tx_en_n;
            busy_q     <= busy_n;
        end
    end

endmodule

// File: tb/tb_diff_tx_serializer.sv
// Bench for diff_tx_serializer: one instance with default parameters and one
// with WIDTH=8, DIV=3, GAP_BITS=0. A receiver model per instance rebuilds words
// from tx_clk rising edges and checks them against a queue of expected words.
module tb_diff_tx_serializer;

    logic clk    = 1'b0;
    bit   clk_en = 1'b0;
    logic rst_a  = 1'b0;
    logic rst_b  = 1'b0;

    always #5 if (clk_en) clk = ~clk;

    diff_tx_serializer_if #(.WIDTH(16)) bus_a ();
    diff_tx_serializer_if #(.WIDTH(8))  bus_b ();

    logic tx_clk_a, tx_data_a, tx_en_a, busy_a;
    logic tx_clk_b, tx_data_b, tx_en_b, busy_b;

    diff_tx_serializer #(.WIDTH(16), .DIV(1), .GAP_BITS(2)) dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .in_bus  (bus_a),
        .tx_clk  (tx_clk_a),
        .tx_data (tx_data_a),
        .tx_en   (tx_en_a),
        .busy    (busy_a)
    );

    diff_tx_serializer #(.WIDTH(8), .DIV(3), .GAP_BITS(0)) dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .in_bus  (bus_b),
        .tx_clk  (tx_clk_b),
        .tx_data (tx_data_b),
        .tx_en   (tx_en_b),
        .busy    (busy_b)
    );

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    int rises_a = 0, first_rise_a = 0;
    int rises_b = 0, first_rise_b = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Receiver model, default instance: sample data on forwarded-clock rises.
    initial begin : mon_a
        logic        prev_clk;
        logic        prev_dat;
        logic [15:0] sr;
        int          nb;
        prev_clk = 1'b0; prev_dat = 1'b0; sr = '0; nb = 0;
        forever begin
            @(negedge clk);
            if (rst_a) begin
                prev_clk = 1'b0; prev_dat = 1'b0; sr = '0; nb = 0;
            end else begin
                if (tx_clk_a) check("stable_while_clk_high_a", tx_data_a, prev_dat);
                if (tx_clk_a && !prev_clk) begin
                    if (nb == 0) first_rise_a = edge_n;
                    sr = {sr[14:0], tx_data_a};
                    nb++;
                    rises_a++;
                    if (nb == 16) begin
                        if (q_a.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL word_a_unexpected: got 0x%0h expected no word", sr);
                        end else begin
                            check("word_a", sr, q_a.pop_front());
                        end
                        nb = 0;
                    end
                end
                prev_clk = tx_clk_a;
                prev_dat = tx_data_a;
            end
        end
    end

    // Receiver model, WIDTH=8 instance.
    initial begin : mon_b
        logic       prev_clk;
        logic       prev_dat;
        logic [7:0] sr;
        int         nb;
        prev_clk = 1'b0; prev_dat = 1'b0; sr = '0; nb = 0;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                prev_clk = 1'b0; prev_dat = 1'b0; sr = '0; nb = 0;
            end else begin
                if (tx_clk_b) check("stable_while_clk_high_b", tx_data_b, prev_dat);
                if (tx_clk_b && !prev_clk) begin
                    if (nb == 0) first_rise_b = edge_n;
                    sr = {sr[6:0], tx_data_b};
                    nb++;
                    rises_b++;
                    if (nb == 8) begin
                        if (q_b.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL word_b_unexpected: got 0x%0h expected no word", sr);
                        end else begin
                            check("word_b", {8'h00, sr}, q_b.pop_front());
                        end
                        nb = 0;
                    end
                end
                prev_clk = tx_clk_b;
                prev_dat = tx_data_b;
            end
        end
    end

    // {in_ready, tx_clk, tx_data, tx_en, busy}
    function automatic logic [4:0] outs(input int sel);
        if (sel == 0) return {bus_a.in_ready, tx_clk_a, tx_data_a, tx_en_a, busy_a};
        return {bus_b.in_ready, tx_clk_b, tx_data_b, tx_en_b, busy_b};
    endfunction

    function automatic int rises(input int sel);
        return (sel == 0) ? rises_a : rises_b;
    endfunction

    function automatic int qsize(input int sel);
        return (sel == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic drive(input int sel, input logic v, input logic [15:0] d);
        if (sel == 0) begin
            bus_a.in_valid = v;
            bus_a.in_data  = d;
        end else begin
            bus_b.in_valid = v;
            bus_b.in_data  = d[7:0];
        end
    endtask

    task automatic push(input int sel, input logic [15:0] w);
        if (sel == 0) q_a.push_back(w);
        else          q_b.push_back(w);
    endtask

    // Called just after a negedge with in_valid high. Returns after the
    // acceptance edge, at the negedge of cycle 1 (acc = edge_n there).
    task automatic wait_accept(input int sel, output int acc);
        int         n;
        logic [4:0] o;
        n = 0;
        o = outs(sel);
        while (o[4] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            o = outs(sel);
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL accept_timeout sel=%0d: got no in_ready in 200 cycles, expected ready", sel);
        end
        @(negedge clk);
        acc = edge_n;
    endtask

    // Walk cycles after acceptance until in_ready returns. Flags: gap_ok when
    // cycles glo..ghi show tx_clk=tx_data=0 with tx_en=busy=1; ctrl_ok when every
    // cycle before ready shows in_ready=0, tx_en=1, busy=1.
    task automatic wait_idle(input int sel, input int acc, input int glo, input int ghi,
                             output int ready_rel, output bit gap_ok, output bit ctrl_ok);
        int         n;
        int         rel;
        logic [4:0] o;
        n = 0; gap_ok = 1'b1; ctrl_ok = 1'b1; ready_rel = -1;
        while (n < 200) begin
            rel = edge_n - acc + 1;
            o   = outs(sel);
            if (o[4] === 1'b1) begin
                ready_rel = rel;
                break;
            end
            if (o[1:0] !== 2'b11) ctrl_ok = 1'b0;
            if (rel >= glo && rel <= ghi && o[3:0] !== 4'b0011) gap_ok = 1'b0;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_word(input int sel, input logic [15:0] d, input logic [15:0] exp_w,
                             input int exp_first, input int exp_ready, input int glo,
                             input int ghi, input int nbits, input string tag);
        int acc, rr, r0, fr;
        bit gok, cok;
        @(negedge clk);
        r0 = rises(sel);
        drive(sel, 1'b1, d);
        push(sel, exp_w);
        wait_accept(sel, acc);
        drive(sel, 1'b0, ~d);
        wait_idle(sel, acc, glo, ghi, rr, gok, cok);
        fr = (sel == 0) ? first_rise_a : first_rise_b;
        check({tag, "_ready_cycle"}, rr, exp_ready);
        check({tag, "_first_rise"}, fr - acc + 1, exp_first);
        check({tag, "_rise_count"}, rises(sel) - r0, nbits);
        check({tag, "_gap_idle"}, gok, 1);
        check({tag, "_busy_ctrl"}, cok, 1);
        check({tag, "_queue_drained"}, qsize(sel), 0);
    endtask

    typedef struct {
        int          sel;
        logic [15:0] data;
        logic [15:0] exp_word;
        int          exp_first;
        int          exp_ready;
        int          glo;
        int          ghi;
        int          nbits;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: got no finish by 500000, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int acc1, acc2, rr, r0;
        bit gok, cok;

        vecs[0] = '{0, 16'hA5C3, 16'hA5C3, 2, 37, 33, 36, 16};
        vecs[1] = '{0, 16'h8000, 16'h8000, 2, 37, 33, 36, 16};
        vecs[2] = '{0, 16'h0000, 16'h0000, 2, 37, 33, 36, 16};
        vecs[3] = '{0, 16'h5A5A, 16'h5A5A, 2, 37, 33, 36, 16};
        vecs[4] = '{1, 16'h0081, 16'h0081, 4, 49,  1,  0,  8};
        vecs[5] = '{1, 16'h00C6, 16'h00C6, 4, 49,  1,  0,  8};

        drive(0, 1'b0, 16'h0);
        drive(1, 1'b0, 16'h0);

        // Asynchronous reset with the clock stopped.
        #3;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check("reset_outs_a", outs(0), 5'b10000);
        check("reset_outs_b", outs(1), 5'b10000);
        clk_en = 1'b1;
        @(negedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_hold_a", outs(0), 5'b10000);
            check("idle_hold_b", outs(1), 5'b10000);
        end

        // Table-driven single words.
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].sel, vecs[i].data, vecs[i].exp_word, vecs[i].exp_first,
                      vecs[i].exp_ready, vecs[i].glo, vecs[i].ghi, vecs[i].nbits,
                      $sformatf("vec%0d", i));
        end

        // Back-to-back words with in_valid held high.
        @(negedge clk);
        r0 = rises_a;
        drive(0, 1'b1, 16'hFFFF);
        push(0, 16'hFFFF);
        wait_accept(0, acc1);
        drive(0, 1'b1, 16'h0001);
        push(0, 16'h0001);
        wait_idle(0, acc1, 33, 36, rr, gok, cok);
        check("b2b_first_ready_cycle", rr, 37);
        check("b2b_first_gap_idle", gok, 1);
        check("b2b_first_busy_ctrl", cok, 1);
        wait_accept(0, acc2);
        check("b2b_accept_spacing", acc2 - acc1, 37);
        drive(0, 1'b0, 16'h0);
        wait_idle(0, acc2, 33, 36, rr, gok, cok);
        check("b2b_second_ready_cycle", rr, 37);
        check("b2b_rise_count", rises_a - r0, 32);
        check("b2b_queue_drained", q_a.size(), 0);

        // Reset mid-word drops the word; the next one goes out cleanly.
        @(negedge clk);
        drive(0, 1'b1, 16'hBEEF);
        push(0, 16'hBEEF);
        wait_accept(0, acc1);
        drive(0, 1'b0, 16'h0);
        repeat (9) @(negedge clk);
        #2;
        rst_a = 1'b1;
        #1;
        check("rst_mid_word_outs", outs(0), 5'b10000);
        q_a.delete();
        @(negedge clk);
        #1;
        check("rst_mid_word_hold", outs(0), 5'b10000);
        rst_a = 1'b0;
        send_word(0, 16'h1234, 16'h1234, 2, 37, 33, 36, 16, "after_rst");

        // Handshake stall: word offered during SHIFT waits for in_ready.
        @(negedge clk);
        drive(0, 1'b1, 16'h3C3C);
        push(0, 16'h3C3C);
        wait_accept(0, acc1);
        drive(0, 1'b0, 16'h0);
        repeat (4) @(negedge clk);
        drive(0, 1'b1, 16'h5555);
        push(0, 16'h5555);
        wait_idle(0, acc1, 33, 36, rr, gok, cok);
        check("stall_ready_cycle", rr, 37);
        check("stall_busy_ctrl", cok, 1);
        wait_accept(0, acc2);
        check("stall_accept_spacing", acc2 - acc1, 37);
        drive(0, 1'b0, 16'h0);
        wait_idle(0, acc2, 33, 36, rr, gok, cok);
        check("stall_second_ready_cycle", rr, 37);
        r0 = rises_a;
        repeat (60) @(negedge clk);
        check("stall_no_extra_rises", rises_a - r0, 0);
        check("stall_queue_drained", q_a.size(), 0);
        check("final_idle_a", outs(0), 5'b10000);
        check("final_idle_b", outs(1), 5'b10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
